// File: rtl/rf_pkg.sv
// Shared constants and write-request bundle for the register-file write arbiter.
// The forwarding path is enabled by defining RF_BYPASS_EN.
package rf_pkg;

  localparam int RF_DW   = 9;
  localparam int RF_AW   = 2;
  localparam int RF_NREQ = 3;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
// One-hot gnt plus its index g; all-zero when en is low.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   g
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    g     = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && !found && valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        g        = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, with
// optional read-port forwarding of the in-flight write (RF_BYPASS_EN).
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rf_wr_en,
  output logic [AW-1:0]     rf_wr_addr,
  output logic [DW-1:0]     rf_wr_data,
  input  logic [AW-1:0]     rd0_addr,
  input  logic [AW-1:0]     rd1_addr,
  input  logic [DW-1:0]     rf_rd0_data,
  input  logic [DW-1:0]     rf_rd1_data,
  output logic [DW-1:0]     rd0_data,
  output logic [DW-1:0]     rd1_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   g;
  logic [NREQ-1:0] gnt;
  logic            pick_en;
  logic            xfer;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q, sel_addr;
  logic [DW-1:0]   wr_data_q, sel_data;

  assign pick_en = rst & ~hold;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .en    (pick_en),
    .gnt   (gnt),
    .g     (g)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);

  always_comb begin
    sel_addr = req_addr[int'(g)*AW +: AW];
    sel_data = req_data[int'(g)*DW +: DW];
    ptr_d    = ptr_q;
    if (xfer) begin
      if (int'(g) == NREQ - 1) ptr_d = '0;
      else                     ptr_d = g + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= xfer;
      if (xfer) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;

`ifdef RF_BYPASS_EN
  // Forward the registered write so a dependent read needs no bubble.
  assign rd0_data = (wr_en_q && rd0_addr == wr_addr_q) ? wr_data_q
                                                       : rf_rd0_data;
  assign rd1_data = (wr_en_q && rd1_addr == wr_addr_q) ? wr_data_q
                                                       : rf_rd1_data;
`else
  logic unused_rd;
  assign unused_rd = ^{rd0_addr, rd1_addr};
  assign rd0_data  = rf_rd0_data;
  assign rd1_data  = rf_rd1_data;
`endif

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Round-robin arbiter that shares the register file's single write port among `NREQ` requesters (ALU result, load return, immediate/move unit). It grants at most one write per cycle, registers the winning address/data and drives the register file's `wr_en`/`wr_addr`/`wr_data`. It also sits on both read paths to optionally forward the in-flight write. It lives between the execute-stage producers and the 4 x 9-bit register file.

## Interface
Parameters:
- `NREQ`, 3: number of write requesters, 2..4.
- `DW`, 9: data width, matches register width.
- `AW`, 2: register address width (4 registers).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hold`  in  1  pipeline stall; while 1, no grant is issued.
- `req_valid`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ*AW  packed target addresses, requester i at `[i*AW +: AW]`.
- `req_data`  in  NREQ*DW  packed write data, requester i at `[i*DW +: DW]`.
- `req_ready`  out  NREQ  one-hot grant; transfer when `req_valid[i] & req_ready[i]`.
- `rf_wr_en`  out  1  register file write enable.
- `rf_wr_addr`  out  AW  register file write address.
- `rf_wr_data`  out  DW  register file write data.
- `rd0_addr`, `rd1_addr`  in  AW  read addresses, also driven to the register file.
- `rf_rd0_data`, `rf_rd1_data`  in  DW  raw register file read data.
- `rd0_data`, `rd1_data`  out  DW  read data delivered to consumers.

## Operation
- Priority pointer `ptr` (0..NREQ-1) names the highest-priority requester. The search order is ptr, ptr+1, ..., wrapping modulo NREQ.
- Grant `g` is the first valid requester in the search order. `req_ready` is combinational, one-hot at `g`, and all-zero if `hold=1`, no valid request exists, or `rst=0`.
- On each rising edge:
  - If a transfer occurs: `rf_wr_en<=1`, `rf_wr_addr<=req_addr[g]`, `rf_wr_data<=req_data[g]`, `ptr<=(g+1) mod NREQ`.
  - If no transfer occurs: `rf_wr_en<=0`, addr and data hold their previous values, and `ptr` is unchanged.
- The output register drains every cycle because the register file never back-pressures. Back-to-back grants are therefore allowed with no bubble.
- Same-address requests in one cycle: only the granted request writes. The loser keeps `req_valid` high and writes on a later cycle, so the last writer is determined by arbitration order.
- Requesters must hold `req_addr`/`req_data` stable while `req_valid=1` and not granted. `req_valid` must not drop before the grant.
- Reset values: `ptr=0`, `rf_wr_en=0`, `rf_wr_addr=0`, `rf_wr_data=0`, `req_ready=0`.
- Reset mid-operation: a registered write is cancelled (`rf_wr_en` cleared asynchronously), and the top level resets the register file from the same source.

## Timing
- Request to grant: 0 cycles (combinational `req_ready`).
- Transfer at edge E1 means `rf_wr_en=1` during cycle E1..E2, and the register file updates at E2.
- Read-after-write: without bypass, `rf_rdN_data` returns the new value only after E2. With bypass, `rdN_data` returns it immediately after E1.
- A `hold` rising mid-cycle removes the grant that cycle. A write already registered still completes.
- Fairness: a continuously valid requester is granted within NREQ cycles while `hold=0`.

## Configuration
- `RF_BYPASS_EN` defined: `rdN_data = (rf_wr_en && rdN_addr==rf_wr_addr) ? rf_wr_data : rf_rdN_data`, applied independently per read port.
- `RF_BYPASS_EN` undefined: `rdN_data = rf_rdN_data` (pure pass-through). The instruction sequencer must insert one bubble between a write and a dependent read.

## Structure
- Shared package `rf_pkg`: `RF_DW=9`, `RF_AW=2`, `RF_NREQ=3`, and a typedef for a `{addr,data}` write request.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `valid[NREQ]`, `ptr` and `en`. Outputs are one-hot `gnt` and index `g`.
- The top level holds the `ptr` register, the output write register and the bypass muxes.

## Test plan
- Reset: assert `rst=0` with all requesters valid, then release. `req_ready=0` during reset, `rf_wr_en=0`, `ptr=0`. The first grant goes to requester 0.
- Round-robin: all three requesters valid for 6 cycles with addrs 1/2/3 and data 0x011/0x022/0x033. Grants follow 0,1,2,0,1,2, and `rf_wr_en` stays high for 6 consecutive cycles.
- Collision: requesters 0 and 2 both target addr 3 with 0x1AA and 0x055, `ptr=0`. Req 0 writes first, then req 2, and reg3 ends at 0x055.
- Hold: `hold=1` for 3 cycles with requester 1 valid. No `req_ready` and no `rf_wr_en` during hold. Grant comes on the first cycle after release, and `ptr` is unchanged during hold.
- Bypass (`RF_BYPASS_EN`): write 0x1FF to addr 2 with `rd0_addr=2`. `rd0_data=0x1FF` in the cycle after the transfer. Without the macro, `rd0_data` shows the old value for that cycle.
- Reset mid-write: drop `rst` while `rf_wr_en=1`. `rf_wr_en` clears immediately, and no write occurs at the next edge.
